// File: rtl/riscv_core_mul_pkg.sv
// Purpose: shared constants, op encodings and FSM state type for the iterative Booth multiplier.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package riscv_core_mul_pkg;

  localparam int XLEN_DEF      = 64;
  // Booth digits needed to cover an XLEN+1 bit operand, and a 36-bit word operand.
  localparam int DW_DIGITS_DEF = (XLEN_DEF + 4) / 4;
  localparam int W_DIGITS_DEF  = 9;

  // {isword, control} as presented by the execute stage.
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_MULW   = 3'b100
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/riscv_core_booth16_pp.sv
// Purpose: radix-16 Booth recoder; turns a 5-bit multiplier window into the signed partial product d*M.
// Latency: combinational.
// Backpressure: none.
// Ports: window (y[4i+3..4i-1]), m (extended multiplicand), m3/m5/m7 (precomputed odd multiples), pp (d*M).
module riscv_core_booth16_pp #(
  parameter int MW  = 68,
  parameter int PPW = 70
) (
  input  logic [4:0]     window,
  input  logic [MW-1:0]  m,
  input  logic [PPW-1:0] m3,
  input  logic [PPW-1:0] m5,
  input  logic [PPW-1:0] m7,
  output logic [PPW-1:0] pp
);

  logic [PPW-1:0] m1;
  logic [3:0]     pos;
  logic [3:0]     mag;
  logic           neg;
  logic [PPW-1:0] mult;

  assign m1  = {{(PPW-MW){m[MW-1]}}, m};
  // Low four window bits contribute 4*y3 + 2*y2 + y1 + y0 (0..8).
  assign pos = {1'b0, window[3:1]} + {3'b000, window[0]};
  assign neg = window[4];
  // With the -8 term present, d = pos - 8, so |d| = 8 - pos.
  assign mag = neg ? (4'd8 - pos) : pos;

  always_comb begin
    mult = '0;
    case (mag)
      4'd1:    mult = m1;
      4'd2:    mult = m1 << 1;
      4'd3:    mult = m3;
      4'd4:    mult = m1 << 2;
      4'd5:    mult = m5;
      4'd6:    mult = m3 << 1;
      4'd7:    mult = m7;
      4'd8:    mult = m1 << 3;
      default: mult = '0;
    endcase
  end

  assign pp = neg ? (~mult + 1'b1) : mult;

endmodule

// File: rtl/riscv_core_mul_booth_seq.sv
// Purpose: iterative radix-16 Booth multiplier for RV64 M-extension ops (MUL/MULH/MULHSU/MULHU/MULW).
// Latency: 17 cycles accept-to-done for doubleword ops, 9 for word ops; done is a one-cycle pulse.
// Backpressure: o_mul_ready low while iterating; valid is ignored until ready returns.
// Ports: i_clk/i_rst_n; i_mul_valid + operands/control/isword request; i_mul_flush kills the op;
//        o_mul_ready, o_mul_busy, o_mul_done, o_mul_result (held until the next completion).
module riscv_core_mul_booth_seq
  import riscv_core_mul_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int DW_DIGITS = DW_DIGITS_DEF,
  parameter int W_DIGITS  = W_DIGITS_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_mul_valid,
  input  logic [XLEN:0]   i_mul_multiplicand,
  input  logic [XLEN:0]   i_mul_multiplier,
  input  logic [1:0]      i_mul_control,
  input  logic            i_mul_isword,
  input  logic            i_mul_flush,
  output logic            o_mul_ready,
  output logic            o_mul_busy,
  output logic            o_mul_done,
  output logic [XLEN-1:0] o_mul_result
);

  localparam int OPW  = XLEN + 1;
  localparam int EXW  = XLEN + 4;   // operand width after sign replication
  localparam int PPW  = XLEN + 6;   // partial product / accumulator width
  localparam int CNTW = $clog2(DW_DIGITS + 1);
  // Word ops shift only 4*W_DIGITS bits into the low register, so the product LSB sits here.
  localparam int WLSB = EXW - 4 * W_DIGITS;

  mul_state_e     state_q, state_d;
  logic           accept, step, last;

  logic [EXW-1:0] m_q, y_q;
  logic           y_prev_q;
  logic [PPW-1:0] m3_q, m5_q, m7_q;
  logic [PPW-1:0] acc_q;
  logic [EXW-1:0] low_q;
  logic [CNTW-1:0] cnt_q;
  logic [1:0]     ctl_q;
  logic           isword_q;
  logic [XLEN-1:0] result_q;

  logic [PPW-1:0] m_in_pp;
  logic [PPW-1:0] pp, sum, acc_nxt;
  logic [EXW-1:0] low_nxt;
  logic [XLEN-1:0] result_d;

  // ---------------- control FSM ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_mul_valid && !i_mul_flush) begin
          accept  = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (i_mul_flush) begin
          state_d = ST_IDLE;
        end else begin
          step = 1'b1;
          if (cnt_q == CNTW'(1)) begin
            last    = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (i_mul_valid && !i_mul_flush) begin
          accept  = 1'b1;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_mul_ready  = (state_q != ST_BUSY);
  assign o_mul_busy   = (state_q == ST_BUSY);
  assign o_mul_done   = (state_q == ST_DONE);
  assign o_mul_result = result_q;

  // ---------------- datapath ----------------
  assign m_in_pp = {{(PPW-OPW){i_mul_multiplicand[OPW-1]}}, i_mul_multiplicand};

  riscv_core_booth16_pp #(
    .MW  (EXW),
    .PPW (PPW)
  ) u_pp (
    .window ({y_q[3:0], y_prev_q}),
    .m      (m_q),
    .m3     (m3_q),
    .m5     (m5_q),
    .m7     (m7_q),
    .pp     (pp)
  );

  // Accumulate, then shift {acc, low} right by one digit; the dropped nibble
  // becomes the next-most-significant nibble of the low product.
  assign sum     = acc_q + pp;
  assign acc_nxt = {{4{sum[PPW-1]}}, sum[PPW-1:4]};
  assign low_nxt = {sum[3:0], low_q[EXW-1:4]};

  // Result is formed from the post-iteration values so it can be registered on the final step.
  always_comb begin
    result_d = '0;
    if (isword_q)
      result_d = {{(XLEN-32){low_nxt[WLSB+31]}}, low_nxt[WLSB +: 32]};
    else if (ctl_q == OP_MUL[1:0])
      result_d = low_nxt[XLEN-1:0];
    else
      result_d = {acc_nxt[XLEN-5:0], low_nxt[EXW-1:XLEN]};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_q      <= '0;
      y_q      <= '0;
      y_prev_q <= 1'b0;
      m3_q     <= '0;
      m5_q     <= '0;
      m7_q     <= '0;
      acc_q    <= '0;
      low_q    <= '0;
      cnt_q    <= '0;
      ctl_q    <= '0;
      isword_q <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      m_q      <= {{(EXW-OPW){i_mul_multiplicand[OPW-1]}}, i_mul_multiplicand};
      y_q      <= {{(EXW-OPW){i_mul_multiplier[OPW-1]}}, i_mul_multiplier};
      y_prev_q <= 1'b0;
      m3_q     <= m_in_pp + (m_in_pp << 1);
      m5_q     <= m_in_pp + (m_in_pp << 2);
      m7_q     <= (m_in_pp << 3) - m_in_pp;
      acc_q    <= '0;
      low_q    <= '0;
      cnt_q    <= i_mul_isword ? CNTW'(W_DIGITS) : CNTW'(DW_DIGITS);
      ctl_q    <= i_mul_control;
      isword_q <= i_mul_isword;
    end else if (step) begin
      acc_q    <= acc_nxt;
      low_q    <= low_nxt;
      y_prev_q <= y_q[3];
      y_q      <= {{4{y_q[EXW-1]}}, y_q[EXW-1:4]};
      cnt_q    <= cnt_q - CNTW'(1);
      if (last) result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_riscv_core_mul_booth_seq.sv
module tb_riscv_core_mul_booth_seq;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_mul_valid;
  logic [64:0] i_mul_multiplicand;
  logic [64:0] i_mul_multiplier;
  logic [1:0]  i_mul_control;
  logic        i_mul_isword;
  logic        i_mul_flush;
  logic        o_mul_ready;
  logic        o_mul_busy;
  logic        o_mul_done;
  logic [63:0] o_mul_result;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sb_q[$];

  riscv_core_mul_booth_seq dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_mul_valid        (i_mul_valid),
    .i_mul_multiplicand (i_mul_multiplicand),
    .i_mul_multiplier   (i_mul_multiplier),
    .i_mul_control      (i_mul_control),
    .i_mul_isword       (i_mul_isword),
    .i_mul_flush        (i_mul_flush),
    .o_mul_ready        (o_mul_ready),
    .o_mul_busy         (o_mul_busy),
    .o_mul_done         (o_mul_done),
    .o_mul_result       (o_mul_result)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [64:0] sx64(input logic [63:0] v);
    return {v[63], v};
  endfunction

  function automatic logic [64:0] zx64(input logic [63:0] v);
    return {1'b0, v};
  endfunction

  function automatic logic [64:0] sx32(input logic [31:0] v);
    return {{33{v[31]}}, v};
  endfunction

  // Reference: exact signed product of the extended operands, then RISC-V result selection.
  function automatic logic [63:0] ref_result(input logic [64:0] m, input logic [64:0] y,
                                             input logic [1:0] ctl, input logic isw);
    logic signed [129:0] ma, ya, p;
    ma = $signed({{65{m[64]}}, m});
    ya = $signed({{65{y[64]}}, y});
    p  = ma * ya;
    if (isw)             return {{32{p[31]}}, p[31:0]};
    else if (ctl == 2'b00) return p[63:0];
    else                 return p[127:64];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one request, returns #1 after the accept edge with valid dropped.
  task automatic start_op(input logic [1:0] ctl, input logic isw, input logic [64:0] m,
                          input logic [64:0] y, input logic [63:0] exp, input bit push);
    i_mul_valid        = 1'b1;
    i_mul_control      = ctl;
    i_mul_isword       = isw;
    i_mul_multiplicand = m;
    i_mul_multiplier   = y;
    if (push) sb_q.push_back(exp);
    @(posedge i_clk);
    #1;
    i_mul_valid = 1'b0;
  endtask

  // Returns #1 after the edge that raised done (or after the cycle budget runs out).
  task automatic wait_done(input string tag, input int lat);
    int cyc;
    logic [63:0] exp;
    cyc = 0;
    while (o_mul_done !== 1'b1 && cyc < 40) begin
      @(posedge i_clk);
      #1;
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(lat));
    if (sb_q.size() > 0) exp = sb_q.pop_front();
    else exp = 'x;
    check({tag, " result"}, o_mul_result, exp);
  endtask

  task automatic idle_edge(input string tag);
    @(posedge i_clk);
    #1;
    check({tag, " done width"}, 64'(o_mul_done), 64'd0);
    check({tag, " ready after"}, 64'(o_mul_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] a, b, exp, held;
    logic [1:0]  ctl;
    logic [64:0] m, y;
    int          dones;

    i_rst_n            = 1'b0;
    i_mul_valid        = 1'b0;
    i_mul_multiplicand = '0;
    i_mul_multiplier   = '0;
    i_mul_control      = 2'b00;
    i_mul_isword       = 1'b0;
    i_mul_flush        = 1'b0;
    #1;
    check("reset ready",  64'(o_mul_ready), 64'd1);
    check("reset busy",   64'(o_mul_busy),  64'd0);
    check("reset done",   64'(o_mul_done),  64'd0);
    check("reset result", o_mul_result,     64'd0);
    #12;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Directed vectors
    start_op(2'b00, 1'b0, sx64(64'd3), sx64(64'hFFFF_FFFF_FFFF_FFFB), 64'hFFFF_FFFF_FFFF_FFF1, 1'b1);
    check("mul busy", 64'(o_mul_busy), 64'd1);
    check("mul ready low", 64'(o_mul_ready), 64'd0);
    wait_done("mul 3x-5", 17);
    idle_edge("mul 3x-5");

    start_op(2'b11, 1'b0, zx64('1), zx64('1), 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    wait_done("mulhu max", 17);
    idle_edge("mulhu max");

    start_op(2'b01, 1'b0, sx64(64'h8000_0000_0000_0000), sx64(64'h8000_0000_0000_0000),
             64'h4000_0000_0000_0000, 1'b1);
    wait_done("mulh min", 17);
    idle_edge("mulh min");

    start_op(2'b10, 1'b0, sx64('1), zx64('1), 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    wait_done("mulhsu", 17);
    idle_edge("mulhsu");

    start_op(2'b00, 1'b1, zx64(64'h0000_0000_7FFF_FFFF), zx64(64'd2), 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    wait_done("mulw", 9);
    idle_edge("mulw");
    held = 64'hFFFF_FFFF_FFFF_FFFE;

    // Flush five cycles in; a simultaneous valid must not be taken
    start_op(2'b00, 1'b0, sx64(64'd12345), sx64(64'd678), 64'd0, 1'b0);
    repeat (4) @(posedge i_clk);
    #1;
    i_mul_flush = 1'b1;
    i_mul_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_mul_flush = 1'b0;
    i_mul_valid = 1'b0;
    check("flush ready",  64'(o_mul_ready), 64'd1);
    check("flush busy",   64'(o_mul_busy),  64'd0);
    check("flush result", o_mul_result,     held);
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      if (o_mul_done === 1'b1) dones++;
      @(posedge i_clk);
      #1;
    end
    check("flush no done", 64'(dones), 64'd0);

    // Flush in IDLE blocks the accept
    i_mul_flush = 1'b1;
    i_mul_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_mul_flush = 1'b0;
    i_mul_valid = 1'b0;
    check("idle flush busy", 64'(o_mul_busy), 64'd0);

    // 7*6, then a back-to-back request issued in the DONE cycle
    start_op(2'b00, 1'b0, sx64(64'd7), sx64(64'd6), 64'd42, 1'b1);
    wait_done("mul 7x6", 17);
    m = sx64(64'hDEAD_BEEF_0123_4567);
    y = sx64(64'h8765_4321_FEDC_BA98);
    start_op(2'b01, 1'b0, m, y, ref_result(m, y, 2'b01, 1'b0), 1'b1);
    check("b2b busy", 64'(o_mul_busy), 64'd1);
    check("b2b done low", 64'(o_mul_done), 64'd0);
    wait_done("b2b mulh", 17);
    idle_edge("b2b mulh");

    // Random operands against the reference product
    for (int i = 0; i < 8; i++) begin
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      ctl = 2'($urandom_range(0, 3));
      if (i >= 6) begin
        m = sx32(a[31:0]);
        y = sx32(b[31:0]);
        start_op(2'b00, 1'b1, m, y, ref_result(m, y, 2'b00, 1'b1), 1'b1);
        wait_done("rand mulw", 9);
      end else begin
        m = (ctl == 2'b11) ? zx64(a) : sx64(a);
        y = (ctl[1]) ? zx64(b) : sx64(b);
        start_op(ctl, 1'b0, m, y, ref_result(m, y, ctl, 1'b0), 1'b1);
        wait_done("rand dw", 17);
      end
      @(posedge i_clk);
      #1;
    end

    // Asynchronous reset in the middle of an op
    start_op(2'b00, 1'b0, sx64(64'd99), sx64(64'd99), 64'd0, 1'b0);
    repeat (3) @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst ready",  64'(o_mul_ready), 64'd1);
    check("arst busy",   64'(o_mul_busy),  64'd0);
    check("arst done",   64'(o_mul_done),  64'd0);
    check("arst result", o_mul_result,     64'd0);
    #3;
    i_rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge i_clk);
      #1;
      if (o_mul_done === 1'b1) dones++;
    end
    check("arst no done", 64'(dones), 64'd0);

    start_op(2'b00, 1'b0, sx64(64'd7), sx64(64'hFFFF_FFFF_FFFF_FFFA),
             64'hFFFF_FFFF_FFFF_FFD6, 1'b1);
    wait_done("post-reset mul", 17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
